// File: rtl/toggle_activity_monitor.sv
// Toggle and high-cycle counter per observed signal over a programmable window;
// results are read back one signal at a time over a valid/ready port.
module toggle_activity_monitor #(
  parameter  int WIDTH = 4,
  parameter  int CNT_W = 16,
  parameter  int WIN_W = 16,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sig_i,
  input  logic             start,
  input  logic [WIN_W-1:0] window_len,
  output logic             busy,
  output logic             done,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_toggles,
  output logic [CNT_W-1:0] rd_high,
  output logic [1:0]       dbg_state
);

  // Handshake: a result word transfers on a rising edge where rd_valid && rd_ready;
  // while rd_valid is high and rd_ready low, rd_idx/rd_toggles/rd_high hold steady.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t                       state_q, state_d;
  logic [WIDTH-1:0]             prev_q, prev_d;
  logic [WIDTH-1:0][CNT_W-1:0]  tog_q, tog_d;
  logic [WIDTH-1:0][CNT_W-1:0]  high_q, high_d;
  logic [WIN_W-1:0]             rem_q, rem_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic                         done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      prev_q  <= '0;
      tog_q   <= '0;
      high_q  <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      tog_q   <= tog_d;
      high_q  <= high_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (window_len == '0) ? S_DRAIN : S_COUNT;
      S_COUNT: if (rem_q == WIN_W'(1)) state_d = S_DRAIN;
      S_DRAIN: if (rd_ready && idx_q == LAST_IDX) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    prev_d = prev_q;
    tog_d  = tog_q;
    high_d = high_q;
    rem_d  = rem_q;
    idx_d  = idx_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          prev_d = sig_i;
          tog_d  = '0;
          high_d = '0;
          rem_d  = window_len;
        end
      end
      S_COUNT: begin
        prev_d = sig_i;
        rem_d  = rem_q - WIN_W'(1);
        for (int i = 0; i < WIDTH; i++) begin
          // Saturate rather than wrap so an overflowed count still reads as "at least max".
          if (sig_i[i] != prev_q[i] && tog_q[i] != CNT_MAX)
            tog_d[i] = tog_q[i] + CNT_W'(1);
          if (sig_i[i] && high_q[i] != CNT_MAX)
            high_d[i] = high_q[i] + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (rd_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            done_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    rd_valid   = (state_q == S_DRAIN);
    done       = done_q;
    rd_idx     = idx_q;
    rd_toggles = tog_q[idx_q];
    rd_high    = high_q[idx_q];
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_toggle_activity_monitor.sv
// Randomized bench for toggle_activity_monitor: a sample-list reference model fills an
// expected queue that the drain phase compares against word by word.
module tb_toggle_activity_monitor;

  localparam int WIDTH = 4;
  localparam int CNT_W = 4;
  localparam int WIN_W = 8;
  localparam int IDX_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] sig_i;
  logic             start;
  logic [WIN_W-1:0] window_len;
  logic             busy, done, rd_valid, rd_ready;
  logic [IDX_W-1:0] rd_idx;
  logic [CNT_W-1:0] rd_toggles, rd_high;
  logic [1:0]       dbg_state;

  logic [WIDTH-1:0]   samp_q[$];
  logic [2*CNT_W-1:0] exp_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  toggle_activity_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk(clk), .rst(rst), .sig_i(sig_i), .start(start), .window_len(window_len),
    .busy(busy), .done(done), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_idx(rd_idx), .rd_toggles(rd_toggles), .rd_high(rd_high), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference: per bit, count transitions along {baseline, samples...} and ones in samples.
  task automatic model(input logic [WIDTH-1:0] base);
    int t, h;
    logic [WIDTH-1:0] seq[$];
    seq = {base};
    foreach (samp_q[k]) seq.push_back(samp_q[k]);
    for (int i = 0; i < WIDTH; i++) begin
      t = 0; h = 0;
      for (int k = 1; k < seq.size(); k++) begin
        if (seq[k][i] != seq[k-1][i]) t++;
        if (seq[k][i]) h++;
      end
      if (t > CMAX) t = CMAX;
      if (h > CMAX) h = CMAX;
      exp_q.push_back({CNT_W'(t), CNT_W'(h)});
    end
  endtask

  // Starts at a falling edge; returns at the falling edge after the last counted sample.
  task automatic run_window(input logic [WIDTH-1:0] base, input int pulse_at);
    int len;
    len = samp_q.size();
    model(base);
    sig_i = base; start = 1'b1; window_len = WIN_W'(len);
    @(negedge clk);
    start = 1'b0;
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL accept_busy got %b want 1", busy); else pass_cnt++;
    for (int k = 0; k < len; k++) begin
      sig_i = samp_q[k];
      start = (k == pulse_at);
      window_len = (k == pulse_at) ? WIN_W'(3) : WIN_W'(len);
      @(negedge clk);
      start = 1'b0;
    end
    chk_cnt++;
    if (rd_valid !== 1'b1) $display("FAIL window_end_valid got %b want 1", rd_valid); else pass_cnt++;
    sig_i = WIDTH'($urandom);
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 3 cycles at idx1. Returns at the done cycle.
  task automatic drain(input int mode);
    int got, cyc, stall;
    logic r;
    logic [2*CNT_W-1:0] e;
    got = 0; cyc = 0; stall = 0;
    while (got < WIDTH && cyc < 100) begin
      e = exp_q[0];
      chk_cnt++;
      if (rd_valid !== 1'b1 || done !== 1'b0 || busy !== 1'b1)
        $display("FAIL drain_flags got v=%b d=%b b=%b want v=1 d=0 b=1", rd_valid, done, busy);
      else pass_cnt++;
      chk_cnt++;
      if (rd_idx !== IDX_W'(got)) $display("FAIL drain_idx got %0d want %0d", rd_idx, got); else pass_cnt++;
      chk_cnt++;
      if (rd_toggles !== e[2*CNT_W-1:CNT_W])
        $display("FAIL toggles[%0d] got %0d want %0d", got, rd_toggles, e[2*CNT_W-1:CNT_W]);
      else pass_cnt++;
      chk_cnt++;
      if (rd_high !== e[CNT_W-1:0])
        $display("FAIL high[%0d] got %0d want %0d", got, rd_high, e[CNT_W-1:0]);
      else pass_cnt++;
      case (mode)
        0: r = 1'b1;
        1: r = 1'($urandom_range(0, 1));
        default: begin
          r = !(got == 1 && stall < 3);
          if (!r) stall++;
        end
      endcase
      rd_ready = r;
      @(negedge clk);
      cyc++;
      if (r) begin got++; void'(exp_q.pop_front()); end
    end
    rd_ready = 1'b0;
    chk_cnt++;
    if (got < WIDTH) $display("FAIL drain_timeout got %0d words want %0d", got, WIDTH); else pass_cnt++;
    chk_cnt++;
    if (done !== 1'b1 || rd_valid !== 1'b0 || busy !== 1'b0 || rd_idx !== '0)
      $display("FAIL done_cycle got d=%b v=%b b=%b idx=%0d want d=1 v=0 b=0 idx=0", done, rd_valid, busy, rd_idx);
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic idle_gap();
    @(negedge clk);
    chk_cnt++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL done_pulse_len got d=%b b=%b want d=0 b=0", done, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; window_len = '0; sig_i = '0; rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (busy !== 1'b0 || done !== 1'b0 || rd_valid !== 1'b0 || rd_idx !== '0 ||
        rd_toggles !== '0 || rd_high !== '0)
      $display("FAIL reset_state got b=%b d=%b v=%b idx=%0d t=%0d h=%0d want all 0",
               busy, done, rd_valid, rd_idx, rd_toggles, rd_high);
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ramp();
    samp_q = {4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    run_window(4'b0000, -1);
    chk_cnt++;
    if (exp_q[0] !== {4'd1, 4'd8} || exp_q[3] !== {4'd1, 4'd5})
      $display("FAIL ramp_model got %h/%h want 18/15", exp_q[0], exp_q[3]);
    else pass_cnt++;
    drain(0);
    idle_gap();
  endtask

  task automatic test_saturation();
    samp_q.delete();
    for (int k = 0; k < 20; k++) samp_q.push_back(WIDTH'(k % 2 == 0));
    run_window('0, -1);
    drain(0);
    idle_gap();
  endtask

  task automatic test_backpressure();
    samp_q.delete();
    for (int k = 0; k < 12; k++) samp_q.push_back(WIDTH'($urandom));
    run_window(WIDTH'($urandom), -1);
    drain(2);
    idle_gap();
  endtask

  task automatic test_zero_window();
    samp_q.delete();
    run_window(4'b1010, -1);
    drain(0);
    idle_gap();
  endtask

  task automatic test_ignored_start();
    samp_q.delete();
    for (int k = 0; k < 10; k++) samp_q.push_back(WIDTH'($urandom));
    run_window(WIDTH'($urandom), 4);
    drain(1);
    idle_gap();
  endtask

  task automatic test_abort();
    sig_i = WIDTH'($urandom); start = 1'b1; window_len = WIN_W'(10);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin sig_i = ~sig_i; @(negedge clk); end
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (busy !== 1'b0 || rd_valid !== 1'b0 || done !== 1'b0)
      $display("FAIL abort_immediate got b=%b v=%b d=%b want 0 0 0", busy, rd_valid, done);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_cnt++;
      if (done !== 1'b0 || busy !== 1'b0 || rd_toggles !== '0 || rd_high !== '0)
        $display("FAIL abort_quiet got d=%b b=%b t=%0d h=%0d want 0 0 0 0", done, busy, rd_toggles, rd_high);
      else pass_cnt++;
    end
    samp_q.delete();
    for (int k = 0; k < 6; k++) samp_q.push_back(WIDTH'($urandom));
    run_window(WIDTH'($urandom), -1);
    drain(0);
    idle_gap();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 3; n++) begin
      samp_q.delete();
      for (int k = 0; k < int'($urandom_range(1, 9)); k++) samp_q.push_back(WIDTH'($urandom));
      run_window(WIDTH'($urandom), -1);
      drain(1);
    end
    idle_gap();
  endtask

  task automatic test_random();
    int len;
    for (int n = 0; n < 8; n++) begin
      samp_q.delete();
      len = $urandom_range(1, 40);
      for (int k = 0; k < len; k++)
        samp_q.push_back(($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : (k == 0 ? 4'b0101 : samp_q[k-1] ^ 4'b0001));
      run_window(WIDTH'($urandom), -1);
      drain(1);
      idle_gap();
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_saturation();
    test_backpressure();
    test_zero_window();
    test_ignored_start();
    test_abort();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/toggle_activity_monitor.md
Name: toggle_activity_monitor

Overview:
- Hardware-side reader of switching activity: observes WIDTH synchronous signals of a DUT over a programmable window of clock cycles.
- Per signal, counts toggles and cycles-at-logic-1. These are the same activity and static-probability figures the power flow extracts from dumped traces.
- After the window closes, results stream out one signal at a time over a valid/ready port, so on-chip activity can be cross-checked against trace-derived numbers.

Parameters:
- WIDTH, 4, number of observed signals (>=1)
- CNT_W, 16, width of every toggle and high-cycle counter (>=2)
- WIN_W, 16, width of window_len

Ports:
- clk  input  1  clock; all inputs synchronous to its rising edge
- rst  input  1  asynchronous, active-high reset
- sig_i  input  WIDTH  observed signals
- start  input  1  request a measurement
- window_len  input  WIN_W  number of counted samples; captured on start acceptance
- busy  output  1  high while not IDLE
- done  output  1  one-cycle pulse after the last result handshake
- rd_valid  output  1  result word valid
- rd_ready  input  1  consumer accepts result
- rd_idx  output  $clog2(WIDTH) (min 1)  signal index of current result
- rd_toggles  output  CNT_W  toggle count of signal rd_idx
- rd_high  output  CNT_W  cycles signal rd_idx sampled as 1

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0, done=0, rd_valid=0, rd_idx=0. All counters and the baseline register clear, so rd_toggles=0 and rd_high=0.
- FSM states: IDLE, COUNT, DRAIN.
- IDLE:
  - start=1 at edge t: baseline prev<=sig_i, all counters<=0, remaining<=window_len.
  - Next state is COUNT, or DRAIN if window_len==0.
  - start is ignored in every other state; window_len is ignored except at acceptance.
- COUNT, each edge:
  - For each bit i: toggles[i]++ if sig_i[i]!=prev[i]; high[i]++ if sig_i[i]==1; prev<=sig_i; remaining--.
  - When remaining==1 at the edge, that sample is counted and state<=DRAIN.
  - Exactly window_len samples are counted, taken on the window_len edges after the acceptance edge.
- Counters saturate at 2^CNT_W-1 and never wrap.
- DRAIN:
  - rd_valid=1; rd_idx starts at 0; rd_toggles/rd_high are combinational selects of counter[rd_idx].
  - On rd_valid&&rd_ready: rd_idx++.
  - On the handshake with rd_idx==WIDTH-1: state<=IDLE, done=1 for exactly the next cycle, rd_idx<=0.
  - While rd_ready=0, rd_valid and data stay stable.
  - sig_i is not sampled in DRAIN; counters hold.
- busy = (state!=IDLE). done is never asserted together with rd_valid.
- Reset mid-COUNT or mid-DRAIN aborts immediately: no done, partial results discarded.
- Counters stay readable only via DRAIN and are cleared at the next start.
- start asserted in the same cycle as done: accepted, since the state is already IDLE.

Test Plan:
- Walking-fill ramp: WIDTH=4, sig_i=0000 at start, window_len=8. Counted samples (bit0 first set) 0001,0011,0111,1111, then 1111 for four more cycles, rd_ready=1 -> four results idx0..3: toggles 1,1,1,1; high 8,7,6,5; done one cycle after idx3.
- Saturation: CNT_W=4, bit0 toggling every cycle from baseline 0, window_len=20 -> idx0 toggles=15 (saturated), high=10; other bits 0,0.
- Backpressure: during DRAIN hold rd_ready=0 for 3 cycles at idx1 -> rd_valid stays 1, rd_idx=1, data constant; completes once rd_ready=1; done only after idx3.
- window_len=0: start with any sig_i -> DRAIN next cycle, all results toggles=0 high=0, then done.
- Ignored start and abort: pulse start mid-COUNT -> no effect on counts or remaining. Second run: assert rst mid-COUNT -> busy=0, rd_valid=0 immediately, no done. A fresh start then yields correct counts with no carry-over.
